// File: rtl/cshm_alphabet_gen.sv
// Alphabet generator for the CSHM FIR: builds the odd multiples 1x..15x of a sample
// with one shared adder/subtractor over seven cycles, then publishes them atomically.
module cshm_alphabet_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] x5,
    output logic [WIDTH-1:0] x7,
    output logic [WIDTH-1:0] x9,
    output logic [WIDTH-1:0] x11,
    output logic [WIDTH-1:0] x13,
    output logic [WIDTH-1:0] x15,
    output logic             out_valid
);

    typedef enum logic [3:0] {IDLE, S3, S5, S7, S9, S11, S13, S15, DONE} state_t;

    state_t state;

    logic signed [WIDTH-1:0] w1, w3, w5, w7, w9, w11, w13;
    logic signed [WIDTH-1:0] op_a, op_b, sum;
    logic                    op_sub;

    // Modulo-2^WIDTH add/subtract; overflow wraps by design.
    function automatic logic signed [WIDTH-1:0] addsub(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input logic                    sub
    );
        return sub ? (a - b) : (a + b);
    endfunction

    // Operand steering for the single shared adder, selected by the current step.
    always_comb begin
        op_a   = w1;
        op_b   = '0;
        op_sub = 1'b0;
        case (state)
            S3:  op_b = w1 <<< 1;
            S5:  op_b = w1 <<< 2;
            S7:  begin op_a = w1 <<< 3; op_b = w1; op_sub = 1'b1; end
            S9:  op_b = w1 <<< 3;
            S11: begin op_a = w9; op_b = w1 <<< 1; end
            S13: begin op_a = w9; op_b = w1 <<< 2; end
            S15: begin op_a = w1 <<< 4; op_b = w1; op_sub = 1'b1; end
            default: ;
        endcase
        sum = addsub(op_a, op_b, op_sub);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            w1  <= '0; w3  <= '0; w5  <= '0; w7  <= '0;
            w9  <= '0; w11 <= '0; w13 <= '0;
            x1  <= '0; x3  <= '0; x5  <= '0; x7  <= '0;
            x9  <= '0; x11 <= '0; x13 <= '0; x15 <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (in_valid) begin
                        w1       <= x_in;
                        state    <= S3;
                        in_ready <= 1'b0;
                    end else begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                S3:  begin w3  <= sum; state <= S5;  end
                S5:  begin w5  <= sum; state <= S7;  end
                S7:  begin w7  <= sum; state <= S9;  end
                S9:  begin w9  <= sum; state <= S11; end
                S11: begin w11 <= sum; state <= S13; end
                S13: begin w13 <= sum; state <= S15; end
                S15: begin
                    // Whole bank is refreshed on this one edge so consumers never see a mix.
                    x1  <= w1;  x3  <= w3;  x5  <= w5;  x7  <= w7;
                    x9  <= w9;  x11 <= w11; x13 <= w13; x15 <= sum;
                    state     <= DONE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cshm_alphabet_gen.sv
// Directed bench for cshm_alphabet_gen with a multiply-based scoreboard of expected banks.
module tb_cshm_alphabet_gen;

    typedef logic [7:0][15:0] bank_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] x_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x1, x3, x5, x7, x9, x11, x13, x15;
    logic        out_valid;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    bank_t sb[$];

    cshm_alphabet_gen #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x3(x3), .x5(x5), .x7(x7), .x9(x9), .x11(x11), .x13(x13), .x15(x15),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic bank_t model(input logic [15:0] x);
        bank_t b;
        logic [31:0] p;
        for (int k = 0; k < 8; k++) begin
            p = x * (2 * k + 1);
            b[k] = p[15:0];
        end
        return b;
    endfunction

    function automatic bank_t cur_bank();
        bank_t b;
        b[0] = x1; b[1] = x3; b[2] = x5;  b[3] = x7;
        b[4] = x9; b[5] = x11; b[6] = x13; b[7] = x15;
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bank_zero(input string tag);
        bank_t b;
        b = cur_bank();
        for (int k = 0; k < 8; k++) check(tag, 32'(b[k]), 32'd0);
    endtask

    // Scoreboard: push on acceptance, pop and compare on each out_valid pulse.
    always @(negedge clk) begin
        bank_t e, a;
        if (out_valid) begin
            pulses++;
            if (sb.size() == 0) begin
                check("stale_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                a = cur_bank();
                for (int k = 0; k < 8; k++) check("bank_sb", 32'(a[k]), 32'(e[k]));
            end
        end
        if (!reset && in_valid && in_ready) sb.push_back(model(x_in));
    end

    task automatic run_sample(input logic [15:0] x);
        int lat;
        in_valid = 1'b1;
        x_in     = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            check("in_ready_busy", 32'(in_ready), 32'd0);
            x_in = 16'($urandom);
        end
        check("latency", lat, 32'd8);
        @(posedge clk); #1;
        check("pulse_width", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int p0;
        reset    = 1'b1;
        in_valid = 1'b1;
        x_in     = 16'h0007;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_bank_zero("reset_bank");
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        run_sample(16'd5);
        check("basic_x1", 32'(x1), 32'd5);
        check("basic_x7", 32'(x7), 32'd35);
        check("basic_x15", 32'(x15), 32'd75);

        run_sample(16'hFFFD);
        check("neg_x3", 32'(x3), 32'hFFF7);
        check("neg_x15", 32'(x15), 32'hFFD3);

        run_sample(16'h2000);
        check("wrap_x5", 32'(x5), 32'hA000);
        check("wrap_x9", 32'(x9), 32'h2000);
        check("wrap_x15", 32'(x15), 32'hE000);

        // Back-to-back with in_valid held high; junk data while busy must be ignored.
        for (int i = 0; i <= 16; i++) begin
            in_valid = (i < 16);
            x_in = (i == 0) ? 16'd1 : (i == 8) ? 16'd2 : 16'($urandom);
            @(negedge clk);
            check("b2b_in_ready", 32'(in_ready), 32'(i % 8 == 0));
            check("b2b_out_valid", 32'(out_valid), 32'(i == 8 || i == 16));
            if (i >= 8 && i < 16) begin
                check("b2b_hold_x1", 32'(x1), 32'd1);
                check("b2b_hold_x15", 32'(x15), 32'd15);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("b2b_x3", 32'(x3), 32'd6);
        check("b2b_x15", 32'(x15), 32'd30);

        p0 = pulses;
        run_sample(16'd9);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("gap_hold_x15", 32'(x15), 32'd135);
            check("gap_in_ready", 32'(in_ready), 32'd1);
        end
        check("gap_pulses", pulses - p0, 32'd1);
        @(posedge clk); #1;

        // Abort in S9: accept, then three more edges reach S9.
        p0 = pulses;
        in_valid = 1'b1;
        x_in     = 16'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.delete();
        reset = 1'b1;
        #1;
        check_bank_zero("abort_bank");
        check("abort_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid2", 32'(out_valid), 32'd0);
        repeat (15) @(negedge clk);
        check("abort_no_pulse", pulses - p0, 32'd0);
        check_bank_zero("abort_bank_later");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cshm_alphabet_gen.md
Name: cshm_alphabet_gen

Overview:
Sequential precomputer ("alphabet generator") for the CSHM FIR filter. It produces the odd multiples x1, x3, …, x15 of an input sample, which the select-and-add multipliers consume together with each coefficient.
It uses a single shared adder/subtractor over 7 cycles instead of 7 parallel adders. All eight multiples are presented on a registered output bank, updated atomically and announced by an out_valid pulse.

Parameters:
WIDTH, 16, sample and alphabet width; all arithmetic is modulo 2^WIDTH (two's complement wrap).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
x_in  input  WIDTH  input sample (two's complement)
in_valid  input  1  x_in is valid
in_ready  output  1  block can accept a sample this cycle
x1  output  WIDTH  1*x (registered, held)
x3  output  WIDTH  3*x
x5  output  WIDTH  5*x
x7  output  WIDTH  7*x
x9  output  WIDTH  9*x
x11  output  WIDTH  11*x
x13  output  WIDTH  13*x
x15  output  WIDTH  15*x
out_valid  output  1  one-cycle pulse: output bank has just been updated

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE
  - all working registers and x1..x15 = 0
  - out_valid=0, in_ready=1 while reset is low in IDLE
- States: IDLE, S3, S5, S7, S9, S11, S13, S15, DONE.
- Acceptance: a sample is accepted on a clk edge where in_valid=1 and in_ready=1.
- in_ready=1 only in IDLE and DONE; it is 0 in S3..S15. While it is 0, in_valid is ignored and the sender must hold its data.
- Accept edge (E0):
  - x_in goes into working register w1
  - state goes to S3
- One shared adder/subtractor. At each edge in state Sk, the result is latched into working register wk:
  - S3: w3 = w1 + (w1<<1)
  - S5: w5 = w1 + (w1<<2)
  - S7: w7 = (w1<<3) - w1
  - S9: w9 = w1 + (w1<<3)
  - S11: w11 = w9 + (w1<<1)
  - S13: w13 = w9 + (w1<<2)
  - S15: w15 = (w1<<4) - w1
- Width rule: shifts are logical left within WIDTH bits. Sum/difference is truncated to WIDTH bits; no saturation, no overflow flag.
- S15 edge (E7):
  - the 15*x result plus w1..w13 are copied into x1..x15 on the same edge
  - state goes to DONE
- out_valid=1 for exactly the DONE cycle and is 0 in all other states.
- x1..x15 change only at the S15 edge (atomic update). They hold their values otherwise, including while a new sample is being processed.
- DONE transitions:
  - with in_valid=1 at the edge: new sample accepted, state goes to S3
  - otherwise: state goes to IDLE
- Latency: outputs are valid 7 edges after the accept edge (out_valid high in the cycle after E7).
- Throughput: one sample per 8 cycles when in_valid is held high.
- Reset mid-computation: aborts immediately. The output bank clears to 0, no out_valid is issued, and the partial sample is discarded.
- in_valid asserted during reset is not accepted.

Test Plan:
- Reset: assert reset mid-operation (state S9) -> x1..x15=0, out_valid=0, in_ready=1 after release; no stale out_valid later.
- Basic: x_in=5 in IDLE -> after 7 edges out_valid pulses one cycle; x1..x15 = 5,15,25,35,45,55,65,75.
- Negative: x_in=0xFFFD (-3) -> x1..x15 = FFFD, FFF7, FFF1, FFEB, FFE5, FFDF, FFD9, FFD3.
- Wrap: x_in=0x2000 -> x1..x15 = 2000, 6000, A000, E000, 2000, 6000, A000, E000 (mod 2^16).
- Back-to-back and hold:
  - in_valid held high with x_in=1, then 2 -> accepts at cycles 0 and 8; out_valid at cycles 8 and 16; bank shows 1..15 odd multiples from cycle 8 to 15, then 2,6,…,30.
  - x_in changed during S3..S15 -> ignored; in_ready=0 there.
- Idle gap: single sample followed by in_valid=0 for 20 cycles -> state returns to IDLE; outputs held unchanged; exactly one out_valid pulse.
